// File: rtl/sell_ticket_pkg.sv
// Shared types and constants for the multi-ticket vending controller:
// FSM state encoding, coin face values and the per-type ticket price table.
package sell_ticket_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    localparam int unsigned COIN_1   = 1;
    localparam int unsigned COIN_5   = 5;
    localparam int unsigned COIN_10  = 10;
    localparam int unsigned COIN_50  = 50;
    localparam int unsigned COIN_100 = 100;

    localparam int unsigned PRICE_TYPES   = 4;
    localparam int unsigned PRICE_IDX_W   = $clog2(PRICE_TYPES);
    localparam int unsigned PRICE [PRICE_TYPES] = '{5, 10, 20, 50};

    typedef struct packed {
        logic c50;
        logic c10;
        logic c5;
        logic c1;
    } change_coins_t;

    // Types beyond the table are priced 0, which the controller treats as unsellable.
    function automatic int unsigned price_of(input int unsigned ticket_idx);
        int unsigned price;
        price = 0;
        if (ticket_idx < PRICE_TYPES) begin
            price = PRICE[ticket_idx[PRICE_IDX_W-1:0]];
        end
        return price;
    endfunction

endpackage

// File: rtl/sell_ticket_multi_change_dispenser.sv
// Greedy change datapath: holds the amount still owed, emits one change coin
// per active cycle (largest that fits) and accumulates the total paid out.
module change_dispenser
    import sell_ticket_pkg::*;
#(
    parameter int unsigned CREDIT_W = 10
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_value,
    input  logic                active,
    output logic                chg1,
    output logic                chg5,
    output logic                chg10,
    output logic                chg50,
    output logic [CREDIT_W-1:0] money_return,
    output logic                empty
);

    localparam int unsigned EXT_W = CREDIT_W + 7;

    logic [CREDIT_W-1:0] remaining_q, remaining_d;
    logic [CREDIT_W-1:0] money_return_q, money_return_d;
    change_coins_t       coins_q, coins_d;
    logic [EXT_W-1:0]    rem_ext;
    logic [CREDIT_W-1:0] step;

    assign rem_ext = {7'd0, remaining_q};

    // Loading starts a fresh payout and clears the reported total.
    always_comb begin
        remaining_d    = remaining_q;
        money_return_d = money_return_q;
        coins_d        = '0;
        step           = '0;
        if (load) begin
            remaining_d    = load_value;
            money_return_d = '0;
        end else if (active && (remaining_q != '0)) begin
            if (rem_ext >= EXT_W'(COIN_50)) begin
                coins_d.c50 = 1'b1;
                step        = CREDIT_W'(COIN_50);
            end else if (rem_ext >= EXT_W'(COIN_10)) begin
                coins_d.c10 = 1'b1;
                step        = CREDIT_W'(COIN_10);
            end else if (rem_ext >= EXT_W'(COIN_5)) begin
                coins_d.c5  = 1'b1;
                step        = CREDIT_W'(COIN_5);
            end else begin
                coins_d.c1  = 1'b1;
                step        = CREDIT_W'(COIN_1);
            end
            remaining_d    = remaining_q - step;
            money_return_d = money_return_q + step;
        end
    end

    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            remaining_q    <= '0;
            money_return_q <= '0;
            coins_q        <= '0;
        end else begin
            remaining_q    <= remaining_d;
            money_return_q <= money_return_d;
            coins_q        <= coins_d;
        end
    end

    assign chg1         = coins_q.c1;
    assign chg5         = coins_q.c5;
    assign chg10        = coins_q.c10;
    assign chg50        = coins_q.c50;
    assign money_return = money_return_q;
    assign empty        = (remaining_q == '0);

endmodule

// File: rtl/sell_ticket_multi.sv
// Multi-type ticket vending controller: collects coins, sells up to MAX_COUNT
// tickets of one type per purchase, then pays back the remaining credit as change.
module sell_ticket_multi
    import sell_ticket_pkg::*;
#(
    parameter int unsigned N_TYPES     = 4,
    parameter int unsigned MAX_COUNT   = 3,
    parameter int unsigned CREDIT_W    = 10,
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned TW = (N_TYPES > 1) ? $clog2(N_TYPES) : 1,
    localparam int unsigned CW = $clog2(MAX_COUNT + 1)
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                ci1,
    input  logic                ci5,
    input  logic                ci10,
    input  logic                ci50,
    input  logic                ci100,
    input  logic [TW-1:0]       ticket_type,
    input  logic [CW-1:0]       ticket_count,
    input  logic                sure,
    input  logic                nsure,
    output logic                short_flag,
    output logic                tkt_valid,
    output logic [TW-1:0]       tkt_type,
    output logic                chg1,
    output logic                chg5,
    output logic                chg10,
    output logic                chg50,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] money_return,
    output logic                busy
);

    localparam int unsigned TOTAL_W = CREDIT_W + CW;
    localparam int unsigned SUM_W   = CREDIT_W + 8;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TO_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]       tickets_left_q, tickets_left_d;
    logic [TW-1:0]       tkt_type_q, tkt_type_d;
    logic                tkt_valid_q, tkt_valid_d;
    logic                short_flag_q, short_flag_d;
    logic                coin_rej_q, coin_rej_d;

    logic                any_coin;
    logic [SUM_W-1:0]    coin_sum;
    logic [SUM_W-1:0]    sum_ext;
    logic                overflow;
    logic [CREDIT_W-1:0] credit_after;
    logic [CREDIT_W-1:0] price;
    logic [TOTAL_W-1:0]  total;
    logic                order_ok;
    logic                timeout;
    logic                disp_load;
    logic [CREDIT_W-1:0] disp_load_value;
    logic                disp_empty;
    logic                change_active;

    assign any_coin = ci1 | ci5 | ci10 | ci50 | ci100;

    assign coin_sum = (ci1   ? SUM_W'(COIN_1)   : SUM_W'(0))
                    + (ci5   ? SUM_W'(COIN_5)   : SUM_W'(0))
                    + (ci10  ? SUM_W'(COIN_10)  : SUM_W'(0))
                    + (ci50  ? SUM_W'(COIN_50)  : SUM_W'(0))
                    + (ci100 ? SUM_W'(COIN_100) : SUM_W'(0));

    // A cycle's coins are accepted all-or-nothing so credit never wraps.
    assign sum_ext      = {8'd0, credit_q} + coin_sum;
    assign overflow     = |sum_ext[SUM_W-1:CREDIT_W];
    assign credit_after = overflow ? credit_q : sum_ext[CREDIT_W-1:0];

    assign price    = CREDIT_W'(price_of(32'(ticket_type)));
    assign total    = {{CW{1'b0}}, price} * {{CREDIT_W{1'b0}}, ticket_count};
    assign order_ok = (ticket_count != '0)
                   && (32'(ticket_count) <= MAX_COUNT)
                   && (32'(ticket_type) < N_TYPES)
                   && (price != '0);

    assign timeout = !any_coin && !sure
                  && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        idle_cnt_d      = '0;
        tickets_left_d  = tickets_left_q;
        tkt_type_d      = tkt_type_q;
        tkt_valid_d     = 1'b0;
        short_flag_d    = 1'b0;
        coin_rej_d      = 1'b0;
        disp_load       = 1'b0;
        disp_load_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_coin) begin
                    if (overflow) begin
                        coin_rej_d = 1'b1;
                    end else begin
                        credit_d = credit_after;
                        state_d  = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                coin_rej_d = any_coin && overflow;
                credit_d   = credit_after;
                if (!any_coin && !sure) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // Cancel beats confirm; the refund includes any coin taken this cycle.
                if (nsure || timeout) begin
                    state_d         = ST_CHANGE;
                    disp_load       = 1'b1;
                    disp_load_value = credit_after;
                    credit_d        = '0;
                    idle_cnt_d      = '0;
                end else if (sure && order_ok) begin
                    if ({{CW{1'b0}}, credit_q} < total) begin
                        short_flag_d = 1'b1;
                    end else begin
                        credit_d       = credit_after - total[CREDIT_W-1:0];
                        tickets_left_d = ticket_count;
                        tkt_type_d     = ticket_type;
                        state_d        = ST_VEND;
                    end
                end
            end

            ST_VEND: begin
                coin_rej_d = any_coin;
                if (tickets_left_q != '0) begin
                    tkt_valid_d    = 1'b1;
                    tickets_left_d = tickets_left_q - 1'b1;
                end
                if (tickets_left_q <= CW'(1)) begin
                    state_d         = ST_CHANGE;
                    disp_load       = 1'b1;
                    disp_load_value = credit_q;
                    credit_d        = '0;
                end
            end

            ST_CHANGE: begin
                coin_rej_d = any_coin;
                if (disp_empty) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            idle_cnt_q     <= '0;
            tickets_left_q <= '0;
            tkt_type_q     <= '0;
            tkt_valid_q    <= 1'b0;
            short_flag_q   <= 1'b0;
            coin_rej_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            idle_cnt_q     <= idle_cnt_d;
            tickets_left_q <= tickets_left_d;
            tkt_type_q     <= tkt_type_d;
            tkt_valid_q    <= tkt_valid_d;
            short_flag_q   <= short_flag_d;
            coin_rej_q     <= coin_rej_d;
        end
    end

    assign change_active = (state_q == ST_CHANGE);

    change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .load         (disp_load),
        .load_value   (disp_load_value),
        .active       (change_active),
        .chg1         (chg1),
        .chg5         (chg5),
        .chg10        (chg10),
        .chg50        (chg50),
        .money_return (money_return),
        .empty        (disp_empty)
    );

    assign short_flag = short_flag_q;
    assign tkt_valid  = tkt_valid_q;
    assign tkt_type   = tkt_type_q;
    assign coin_rej   = coin_rej_q;
    assign credit     = credit_q;
    assign busy       = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_sell_ticket_multi.sv
// Directed bench for sell_ticket_multi: purchases, short credit, cancel,
// timeout refund, coin overflow/rejection and reset in the middle of a vend.
module tb_sell_ticket_multi;
    import sell_ticket_pkg::*;

    localparam int unsigned N_TYPES     = 4;
    localparam int unsigned MAX_COUNT   = 3;
    localparam int unsigned CREDIT_W    = 10;
    localparam int unsigned TIMEOUT_CYC = 1000;
    localparam int unsigned TW = 2;
    localparam int unsigned CW = 2;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] C1   = 5'b00001;
    localparam logic [4:0] C5   = 5'b00010;
    localparam logic [4:0] C10  = 5'b00100;
    localparam logic [4:0] C50  = 5'b01000;
    localparam logic [4:0] C100 = 5'b10000;

    logic                clk_sys = 1'b0;
    logic                rst     = 1'b1;
    logic                ci1 = 1'b0, ci5 = 1'b0, ci10 = 1'b0, ci50 = 1'b0, ci100 = 1'b0;
    logic [TW-1:0]       ticket_type  = '0;
    logic [CW-1:0]       ticket_count = '0;
    logic                sure = 1'b0, nsure = 1'b0;
    logic                short_flag, tkt_valid, coin_rej, busy;
    logic [TW-1:0]       tkt_type;
    logic                chg1, chg5, chg10, chg50;
    logic [CREDIT_W-1:0] credit, money_return;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int nTkt, nCoins, n50, n10, n5, n1, overlap, tktTypeBad, coinSeq;
    bit timedOut;

    sell_ticket_multi #(
        .N_TYPES     (N_TYPES),
        .MAX_COUNT   (MAX_COUNT),
        .CREDIT_W    (CREDIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .ci1          (ci1),
        .ci5          (ci5),
        .ci10         (ci10),
        .ci50         (ci50),
        .ci100        (ci100),
        .ticket_type  (ticket_type),
        .ticket_count (ticket_count),
        .sure         (sure),
        .nsure        (nsure),
        .short_flag   (short_flag),
        .tkt_valid    (tkt_valid),
        .tkt_type     (tkt_type),
        .chg1         (chg1),
        .chg5         (chg5),
        .chg10        (chg10),
        .chg50        (chg50),
        .coin_rej     (coin_rej),
        .credit       (credit),
        .money_return (money_return),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes; returns 1ns after the edge that sampled them.
    task automatic applyStimulus(input logic [4:0] coins, input logic s, input logic ns);
        {ci100, ci50, ci10, ci5, ci1} = coins;
        sure  = s;
        nsure = ns;
        @(posedge clk_sys);
        #1;
        {ci100, ci50, ci10, ci5, ci1} = NONE;
        sure  = 1'b0;
        nsure = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk_sys);
        #1;
    endtask

    // Watch tickets and change coins until the machine is idle again (bounded).
    task automatic collectRun(input int limit, input logic [TW-1:0] expType);
        int hits;
        int coinVal;
        nTkt = 0; nCoins = 0; n50 = 0; n10 = 0; n5 = 0; n1 = 0;
        overlap = 0; tktTypeBad = 0; coinSeq = 0; timedOut = 1'b1;
        for (int i = 0; i < limit; i++) begin
            idleCycle();
            hits = int'(tkt_valid) + int'(chg1) + int'(chg5) + int'(chg10) + int'(chg50);
            if (hits > 1) overlap++;
            if (tkt_valid) begin
                nTkt++;
                if (tkt_type !== expType) tktTypeBad++;
            end
            coinVal = chg50 ? 50 : chg10 ? 10 : chg5 ? 5 : chg1 ? 1 : 0;
            if (chg50) n50++;
            if (chg10) n10++;
            if (chg5)  n5++;
            if (chg1)  n1++;
            if (coinVal != 0) begin
                nCoins++;
                if (nCoins <= 4) coinSeq = coinSeq * 100 + coinVal;
            end
            if (!busy && hits == 0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;

        // Reset state
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_credit", 32'(credit), 0);
        checkOutput("reset_money_return", 32'(money_return), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_strobes", 32'({tkt_valid, chg1, chg5, chg10, chg50, coin_rej, short_flag}), 0);
        repeat (2) @(posedge clk_sys);
        #1 rst = 1'b1;

        // Type 3 x3 paid with one of every coin at once: 166 - 150 = 16 change
        ticket_type = 2'd3; ticket_count = 2'd3;
        applyStimulus(C100 | C50 | C10 | C5 | C1, 1'b0, 1'b0);
        checkOutput("sum_all_coins", 32'(credit), 166);
        checkOutput("collect_not_busy", 32'(busy), 0);
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("vend_credit_left", 32'(credit), 16);
        checkOutput("vend_busy", 32'(busy), 1);
        checkOutput("vend_no_pulse_on_entry", 32'(tkt_valid), 0);
        collectRun(20, 2'd3);
        checkOutput("t34_tickets", 32'(nTkt), 3);
        checkOutput("t34_ticket_type", 32'(tktTypeBad), 0);
        checkOutput("t34_change_seq", 32'(coinSeq), 100501);
        checkOutput("t34_money_return", 32'(money_return), 16);
        checkOutput("t34_one_hot", 32'(overlap), 0);
        checkOutput("t34_done", 32'(timedOut), 0);
        checkOutput("t34_credit_cleared", 32'(credit), 0);

        // Short credit, then top up and buy type 1 x2: 55 - 20 = 35 change
        ticket_type = 2'd1; ticket_count = 2'd0;
        applyStimulus(C5, 1'b0, 1'b0);
        checkOutput("t35_credit5", 32'(credit), 5);
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("count0_no_short", 32'(short_flag), 0);
        checkOutput("count0_not_busy", 32'(busy), 0);
        ticket_count = 2'd2;
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("short_flag_pulse", 32'(short_flag), 1);
        checkOutput("short_state_collect", 32'(dut.state_q), 32'(ST_COLLECT));
        checkOutput("short_credit_kept", 32'(credit), 5);
        idleCycle();
        checkOutput("short_flag_one_cycle", 32'(short_flag), 0);
        applyStimulus(C50, 1'b0, 1'b0);
        checkOutput("t35_credit55", 32'(credit), 55);
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("t35_credit_left", 32'(credit), 35);
        collectRun(20, 2'd1);
        checkOutput("t35_tickets", 32'(nTkt), 2);
        checkOutput("t35_change_seq", 32'(coinSeq), 10101005);
        checkOutput("t35_money_return", 32'(money_return), 35);
        checkOutput("t35_done", 32'(timedOut), 0);

        // sure and nsure together: cancel wins, full refund of 30
        ticket_type = 2'd0; ticket_count = 2'd1;
        repeat (3) applyStimulus(C10, 1'b0, 1'b0);
        checkOutput("t36_credit30", 32'(credit), 30);
        applyStimulus(NONE, 1'b1, 1'b1);
        checkOutput("t36_cancel_busy", 32'(busy), 1);
        collectRun(20, 2'd0);
        checkOutput("t36_no_tickets", 32'(nTkt), 0);
        checkOutput("t36_change_seq", 32'(coinSeq), 101010);
        checkOutput("t36_money_return", 32'(money_return), 30);
        checkOutput("t36_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Timeout refund of a single coin
        applyStimulus(C1, 1'b0, 1'b0);
        checkOutput("t37_credit1", 32'(credit), 1);
        repeat (TIMEOUT_CYC - 1) idleCycle();
        checkOutput("t37_no_early_timeout", 32'(busy), 0);
        checkOutput("t37_credit_held", 32'(credit), 1);
        collectRun(10, 2'd0);
        checkOutput("t37_change_seq", 32'(coinSeq), 1);
        checkOutput("t37_coins", 32'(nCoins), 1);
        checkOutput("t37_money_return", 32'(money_return), 1);
        checkOutput("t37_done", 32'(timedOut), 0);

        // Credit ceiling 1023 and coins refused during a vend
        repeat (10) applyStimulus(C100, 1'b0, 1'b0);
        repeat (2) applyStimulus(C10, 1'b0, 1'b0);
        checkOutput("t38_credit1020", 32'(credit), 1020);
        applyStimulus(C10, 1'b0, 1'b0);
        checkOutput("t38_overflow_rej", 32'(coin_rej), 1);
        checkOutput("t38_credit_kept", 32'(credit), 1020);
        idleCycle();
        checkOutput("t38_rej_one_cycle", 32'(coin_rej), 0);
        repeat (3) applyStimulus(C1, 1'b0, 1'b0);
        checkOutput("t38_credit_max", 32'(credit), 1023);
        applyStimulus(C1, 1'b0, 1'b0);
        checkOutput("t38_max_plus1_rej", 32'(coin_rej), 1);
        checkOutput("t38_max_kept", 32'(credit), 1023);
        ticket_type = 2'd3; ticket_count = 2'd1;
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("t38_credit_left", 32'(credit), 973);
        applyStimulus(C5, 1'b0, 1'b0);
        checkOutput("t38_vend_coin_rej", 32'(coin_rej), 1);
        checkOutput("t38_ticket", 32'(tkt_valid), 1);
        checkOutput("t38_ticket_type", 32'(tkt_type), 3);
        collectRun(40, 2'd3);
        checkOutput("t38_n50", 32'(n50), 19);
        checkOutput("t38_n10", 32'(n10), 2);
        checkOutput("t38_n1", 32'(n1), 3);
        checkOutput("t38_n5", 32'(n5), 0);
        checkOutput("t38_money_return", 32'(money_return), 973);
        checkOutput("t38_one_hot", 32'(overlap), 0);
        checkOutput("t38_done", 32'(timedOut), 0);

        // Reset during the second ticket of a three-ticket vend (exact credit 60)
        ticket_type = 2'd2; ticket_count = 2'd3;
        applyStimulus(C50 | C10, 1'b0, 1'b0);
        checkOutput("t39_credit60", 32'(credit), 60);
        applyStimulus(NONE, 1'b1, 1'b0);
        checkOutput("t39_exact_credit_vend", 32'(busy), 1);
        idleCycle();
        checkOutput("t39_first_ticket", 32'(tkt_valid), 1);
        idleCycle();
        checkOutput("t39_second_ticket", 32'(tkt_valid), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t39_rst_tkt_valid", 32'(tkt_valid), 0);
        checkOutput("t39_rst_tkt_type", 32'(tkt_type), 0);
        checkOutput("t39_rst_busy", 32'(busy), 0);
        checkOutput("t39_rst_money_return", 32'(money_return), 0);
        checkOutput("t39_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("t39_rst_strobes", 32'({chg1, chg5, chg10, chg50, coin_rej, short_flag}), 0);
        @(posedge clk_sys);
        #1 rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            idleCycle();
            pulses += int'(tkt_valid) + int'(chg1) + int'(chg5) + int'(chg10) + int'(chg50) + int'(busy);
        end
        checkOutput("t39_no_pulses_after_reset", 32'(pulses), 0);
        checkOutput("t39_credit_after_reset", 32'(credit), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
